// File: rtl/alu_issue_stage.sv
// ALU issue stage: single-entry valid/ready pipe register ahead of execute.
// Optional perf counters (stall_cnt, issue_cnt) when ALU_ISSUE_PERF_EN is defined.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic              flush,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [3:0]        out_alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       issue_cnt
`endif
);

  logic              accept;
  logic [XLEN-1:0]   a_d;
  logic [XLEN-1:0]   b_d;
  logic [XLEN-1:0]   a_ref;
  logic [XLEN-1:0]   b_ref;
  logic [3:0]        op_d;
  logic              ill_d;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              imm_q;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // MEM beats WB beats the supplied value; x0 is always zero
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] ra,
    input logic [XLEN-1:0]   dflt,
    input logic              m_en,
    input logic [REG_AW-1:0] m_rd,
    input logic [XLEN-1:0]   m_data,
    input logic              w_en,
    input logic [REG_AW-1:0] w_rd,
    input logic [XLEN-1:0]   w_data
  );
    if (ra == '0)
      return '0;
    else if (m_en && m_rd == ra)
      return m_data;
    else if (w_en && w_rd == ra)
      return w_data;
    else
      return dflt;
  endfunction

  // operand select and forwarding for incoming and held ops
  always_comb begin
    a_d = fwd(in_rs1, in_rs1_data,
              mem_fwd_en, mem_fwd_rd, mem_fwd_data,
              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    b_d = in_imm;
    if (!in_use_imm)
      b_d = fwd(in_rs2, in_rs2_data,
                mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    a_ref = fwd(rs1_q, out_a,
                mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    b_ref = out_b;
    if (!imm_q)
      b_ref = fwd(rs2_q, out_b,
                  mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                  wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  end

  // funct3/funct7b5 to ALU opcode; bad encodings issue as 0000
  always_comb begin
    op_d  = 4'b0000;
    ill_d = 1'b0;
    unique case (in_funct3)
      3'b000: op_d = (in_funct7b5 & !in_use_imm) ? 4'b0001 : 4'b0000;
      3'b001: begin
        op_d  = 4'b0101;
        ill_d = in_funct7b5;
      end
      3'b010: begin
        op_d  = 4'b1000;
        ill_d = in_funct7b5 & !in_use_imm;
      end
      3'b011: begin
        op_d  = 4'b1001;
        ill_d = in_funct7b5 & !in_use_imm;
      end
      3'b100: begin
        op_d  = 4'b0100;
        ill_d = in_funct7b5 & !in_use_imm;
      end
      3'b101: op_d = in_funct7b5 ? 4'b0111 : 4'b0110;
      3'b110: begin
        op_d  = 4'b0011;
        ill_d = in_funct7b5 & !in_use_imm;
      end
      3'b111: begin
        op_d  = 4'b0010;
        ill_d = in_funct7b5 & !in_use_imm;
      end
      default: op_d = 4'b0000;
    endcase
    if (ill_d)
      op_d = 4'b0000;
  end

  // entry state: load on accept, drop on consume/flush, refresh while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_alu_op  <= 4'b0000;
      out_rd      <= '0;
      out_illegal <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_a       <= a_d;
      out_b       <= b_d;
      out_alu_op  <= op_d;
      out_rd      <= in_rd;
      out_illegal <= ill_d;
      rs1_q       <= in_rs1;
      rs2_q       <= in_rs2;
      imm_q       <= in_use_imm;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      out_a <= a_ref;
      out_b <= b_ref;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // free-running stall/issue counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (out_valid && out_ready)
        issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Inputs change 1ns after rising edges; outputs are sampled there too.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic        flush;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] issue_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd),
    .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_rs1       = '0;
    in_rs2       = '0;
    in_rd        = '0;
    in_rs1_data  = '0;
    in_rs2_data  = '0;
    in_imm       = '0;
    in_use_imm   = 1'b0;
    in_funct3    = '0;
    in_funct7b5  = 1'b0;
    flush        = 1'b0;
    mem_fwd_en   = 1'b0;
    mem_fwd_rd   = '0;
    mem_fwd_data = '0;
    wb_fwd_en    = 1'b0;
    wb_fwd_rd    = '0;
    wb_fwd_data  = '0;
  endtask

  task automatic set_op(
    input logic [4:0]  rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
    input logic        ui, input logic [2:0] f3, input logic f7
  );
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = imm;
    in_use_imm  = ui;
    in_funct3   = f3;
    in_funct7b5 = f7;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    out_ready = 1'b1;
    #3;
    checks++;
    if ({out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got v=%0b a=%h b=%h op=%b rd=%0d ill=%0b, want all 0",
               out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sub();
    set_op(5'd1, 5'd2, 5'd11, 32'd10, 32'd3, 32'd0, 1'b0, 3'b000, 1'b1);
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_alu_op, out_a, out_b, out_illegal, out_rd} !==
        {1'b1, 4'b0001, 32'd10, 32'd3, 1'b0, 5'd11}) begin
      errors++;
      $display("FAIL sub: got v=%0b op=%b a=%0d b=%0d ill=%0b rd=%0d, want 1 0001 10 3 0 11",
               out_valid, out_alu_op, out_a, out_b, out_illegal, out_rd);
    end
    idle();
    tick();
  endtask

  task automatic test_srai();
    set_op(5'd1, 5'd2, 5'd12, 32'd40, 32'd99, 32'd4, 1'b1, 3'b101, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_alu_op, out_b} !== {1'b1, 4'b0111, 32'd4}) begin
      errors++;
      $display("FAIL srai: got v=%0b op=%b b=%0d, want 1 0111 4",
               out_valid, out_alu_op, out_b);
    end
    idle();
    tick();
  endtask

  task automatic test_forward();
    mem_fwd_en   = 1'b1;
    mem_fwd_rd   = 5'd5;
    mem_fwd_data = 32'hAAAA;
    wb_fwd_en    = 1'b1;
    wb_fwd_rd    = 5'd5;
    wb_fwd_data  = 32'hBBBB;
    set_op(5'd5, 5'd5, 5'd1, 32'h1111, 32'h2222, 32'd0, 1'b0, 3'b110, 1'b0);
    tick();
    checks++;
    if ({out_a, out_b} !== {32'hAAAA, 32'hAAAA}) begin
      errors++;
      $display("FAIL fwd_mem_prio: got a=%h b=%h want 0000aaaa 0000aaaa", out_a, out_b);
    end
    set_op(5'd0, 5'd6, 5'd1, 32'h5555, 32'h6666, 32'd0, 1'b0, 3'b110, 1'b0);
    wb_fwd_rd = 5'd6;
    tick();
    checks++;
    if ({out_a, out_b} !== {32'h0, 32'hBBBB}) begin
      errors++;
      $display("FAIL fwd_x0_wb: got a=%h b=%h want 00000000 0000bbbb", out_a, out_b);
    end
    idle();
    tick();
  endtask

  task automatic test_illegal();
    set_op(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 1'b0, 3'b110, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_illegal, out_alu_op} !== {1'b1, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL ill_r_or: got v=%0b ill=%0b op=%b want 1 1 0000",
               out_valid, out_illegal, out_alu_op);
    end
    set_op(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd7, 1'b1, 3'b001, 1'b1);
    tick();
    checks++;
    if ({out_illegal, out_alu_op} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL ill_i_sll: got ill=%0b op=%b want 1 0000", out_illegal, out_alu_op);
    end
    set_op(5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd7, 1'b1, 3'b110, 1'b1);
    tick();
    checks++;
    if ({out_illegal, out_alu_op} !== {1'b0, 4'b0011}) begin
      errors++;
      $display("FAIL ori_legal: got ill=%0b op=%b want 0 0011", out_illegal, out_alu_op);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_refresh();
    out_ready = 1'b0;
    set_op(5'd3, 5'd7, 5'd8, 32'h22, 32'h11, 32'd0, 1'b0, 3'b000, 1'b0);
    tick();
    checks++;
    if ({out_valid, out_b, in_ready} !== {1'b1, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL stall_load: got v=%0b b=%h rdy=%0b want 1 00000011 0",
               out_valid, out_b, in_ready);
    end
    set_op(5'd4, 5'd4, 5'd9, 32'h99, 32'h99, 32'd0, 1'b0, 3'b100, 1'b0);
    tick();
    wb_fwd_en   = 1'b1;
    wb_fwd_rd   = 5'd7;
    wb_fwd_data = 32'h1234;
    tick();
    wb_fwd_en = 1'b0;
    checks++;
    if ({out_b, out_a, out_alu_op, out_rd, in_ready} !==
        {32'h1234, 32'h22, 4'b0000, 5'd8, 1'b0}) begin
      errors++;
      $display("FAIL stall_refresh: got b=%h a=%h op=%b rd=%0d rdy=%0b want 00001234 00000022 0000 8 0",
               out_b, out_a, out_alu_op, out_rd, in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_b, out_rd, in_ready} !== {1'b1, 32'h1234, 5'd8, 1'b0}) begin
      errors++;
      $display("FAIL stall_hold: got v=%0b b=%h rd=%0d rdy=%0b want 1 00001234 8 0",
               out_valid, out_b, out_rd, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_rd} !== {1'b0, 5'd8}) begin
      errors++;
      $display("FAIL stall_consume: got v=%0b rd=%0d want 0 8", out_valid, out_rd);
    end
    idle();
  endtask

  task automatic test_imm_hold();
    out_ready = 1'b0;
    set_op(5'd1, 5'd7, 5'd2, 32'd64, 32'd5, 32'd4, 1'b1, 3'b101, 1'b1);
    tick();
    in_valid    = 1'b0;
    wb_fwd_en   = 1'b1;
    wb_fwd_rd   = 5'd7;
    wb_fwd_data = 32'h1234;
    tick();
    checks++;
    if ({out_b, out_alu_op} !== {32'd4, 4'b0111}) begin
      errors++;
      $display("FAIL imm_hold: got b=%h op=%b want 00000004 0111", out_b, out_alu_op);
    end
    idle();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_op(5'd2, 5'd0, 5'd3, 32'h77, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
    tick();
    set_op(5'd4, 5'd0, 5'd9, 32'h88, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got %0b want 1", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_rd, out_a} !== {1'b0, 5'd3, 32'h77}) begin
      errors++;
      $display("FAIL flush_drop: got v=%0b rd=%0d a=%h want 0 3 00000077",
               out_valid, out_rd, out_a);
    end
    idle();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_op(5'(i), 5'd0, 5'(i + 16), 32'(i * 16), 32'd0, 32'd0, 1'b0, 3'b100, 1'b0);
      tick();
      checks++;
      if ({out_valid, out_rd, out_a, out_alu_op} !==
          {1'b1, 5'(i + 16), 32'(i * 16), 4'b0100}) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%0b rd=%0d a=%h op=%b", i,
                 out_valid, out_rd, out_a, out_alu_op);
      end
    end
    idle();
    tick();
    checks++;
    if ({out_valid, out_rd, out_a} !== {1'b0, 5'd20, 32'd64}) begin
      errors++;
      $display("FAIL b2b_drain: got v=%0b rd=%0d a=%h want 0 20 00000040",
               out_valid, out_rd, out_a);
    end
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0;
    set_op(5'd1, 5'd2, 5'd5, 32'h33, 32'h44, 32'd0, 1'b0, 3'b111, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_rst: got v=%0b want 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal, in_ready} !==
        {1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst: got v=%0b a=%h b=%h op=%b rd=%0d ill=%0b rdy=%0b want zeros rdy=1",
               out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal, in_ready);
    end
    #1;
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_srai();
    test_forward();
    test_illegal();
    test_stall_refresh();
    test_imm_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
